// File: rtl/moldudp64_pkg.sv
// Shared widths, MoldUDP64 special message counts and the sequence controller state type.
package moldudp64_pkg;

  localparam int unsigned SID_W = 80;
  localparam int unsigned SEQ_W = 64;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] MOLD_EOS_CNT = 16'hFFFF;
  localparam logic [CNT_W-1:0] MOLD_HB_CNT  = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PKT,
    ST_DROP,
    ST_EOS
  } seq_state_e;

endpackage

// File: rtl/mold_seq_cmp.sv
// Serial-number comparison of a packet header against the expected sequence number.
module mold_seq_cmp
  import moldudp64_pkg::*;
(
  input  logic [SEQ_W-1:0] exp_seq,
  input  logic [SEQ_W-1:0] hdr_seq,
  input  logic [CNT_W-1:0] hdr_cnt,
  output logic [SEQ_W-1:0] d,
  output logic             in_order,
  output logic             ahead,
  output logic             behind,
  output logic             dup_full,
  output logic [CNT_W-1:0] skip
);

  logic [SEQ_W-1:0] end_d;

  always_comb begin
    d        = hdr_seq - exp_seq;
    in_order = (d == '0);
    ahead    = !in_order && !d[SEQ_W-1];
    behind   = !in_order && d[SEQ_W-1];
    // Packet end at or before exp means every message is already seen.
    end_d    = hdr_seq + SEQ_W'(hdr_cnt) - exp_seq;
    dup_full = behind && ((end_d == '0) || end_d[SEQ_W-1]);
    skip     = CNT_W'(exp_seq - hdr_seq);
  end

endmodule

// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 per-session sequence tracker: commit/discard verdict per message plus
// gap, duplicate, session, count and end-of-session reporting.
module mold_seq_ctrl
  import moldudp64_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_v_i,
  input  logic [SID_W-1:0] hdr_sid_i,
  input  logic [SEQ_W-1:0] hdr_seq_i,
  input  logic [CNT_W-1:0] hdr_cnt_i,
  input  logic             msg_end_v_i,
  input  logic             pkt_last_i,
  output logic             msg_v_o,
  output logic             msg_keep_o,
  output logic [SEQ_W-1:0] msg_seq_o,
  output logic [SEQ_W-1:0] exp_seq_o,
  output logic             gap_v_o,
  output logic [SEQ_W-1:0] gap_start_o,
  output logic [SEQ_W-1:0] gap_len_o,
  output logic             sid_err_o,
  output logic             cnt_err_o,
  output logic             eos_o
);

  seq_state_e       state_q, state_d, state_w;
  logic [SID_W-1:0] sid_q, sid_d;
  logic [SEQ_W-1:0] exp_q, exp_d, exp_w;
  logic [SEQ_W-1:0] cur_q, cur_d, cur_w;
  logic [CNT_W-1:0] rem_q, rem_d, rem_w;
  logic [CNT_W-1:0] skip_q, skip_d, skip_w;

  logic             msg_keep_d;
  logic [SEQ_W-1:0] msg_seq_d;
  logic             cnt_err_d;
  logic             gap_v_d;
  logic [SEQ_W-1:0] gap_start_d, gap_len_d;
  logic             sid_err_d;

  logic [SEQ_W-1:0] cmp_exp, cmp_d;
  logic             cmp_in_order, cmp_ahead, cmp_behind, cmp_dup_full;
  logic [CNT_W-1:0] cmp_skip;

  // Message stage then packet-close stage; the header stage sees the result.
  always_comb begin
    state_w    = state_q;
    exp_w      = exp_q;
    cur_w      = cur_q;
    rem_w      = rem_q;
    skip_w     = skip_q;
    msg_keep_d = 1'b0;
    msg_seq_d  = msg_seq_o;
    cnt_err_d  = 1'b0;

    if (msg_end_v_i) begin
      msg_seq_d = exp_q;
      if (state_q == ST_PKT) begin
        msg_seq_d = cur_q;
        if (rem_q != '0) begin
          msg_keep_d = (skip_q == '0);
          cur_w      = cur_q + SEQ_W'(1);
          rem_w      = rem_q - CNT_W'(1);
          if (skip_q != '0) begin
            skip_w = skip_q - CNT_W'(1);
          end
        end else begin
          cnt_err_d = 1'b1;
        end
      end
    end

    // A new header without a preceding last beat closes the packet too.
    if ((pkt_last_i || hdr_v_i) && (state_q == ST_PKT || state_q == ST_DROP)) begin
      if (state_q == ST_PKT && rem_w != '0) begin
        cnt_err_d = 1'b1;
        exp_w     = cur_w;
      end
      state_w = ST_WAIT;
    end
  end

  assign cmp_exp = (state_w == ST_IDLE) ? hdr_seq_i : exp_w;

  mold_seq_cmp u_cmp (
    .exp_seq  (cmp_exp),
    .hdr_seq  (hdr_seq_i),
    .hdr_cnt  (hdr_cnt_i),
    .d        (cmp_d),
    .in_order (cmp_in_order),
    .ahead    (cmp_ahead),
    .behind   (cmp_behind),
    .dup_full (cmp_dup_full),
    .skip     (cmp_skip)
  );

  // Header stage: next state and packet bookkeeping.
  always_comb begin
    state_d     = state_w;
    sid_d       = sid_q;
    exp_d       = exp_w;
    cur_d       = cur_w;
    rem_d       = rem_w;
    skip_d      = skip_w;
    gap_v_d     = 1'b0;
    gap_start_d = gap_start_o;
    gap_len_d   = gap_len_o;
    sid_err_d   = 1'b0;

    if (hdr_v_i && (state_w == ST_IDLE || state_w == ST_WAIT)) begin
      if (state_w == ST_IDLE) begin
        sid_d = hdr_sid_i;
        exp_d = hdr_seq_i;
      end
      if (state_w == ST_WAIT && hdr_sid_i != sid_q) begin
        sid_err_d = 1'b1;
        state_d   = ST_DROP;
      end else if (hdr_cnt_i == MOLD_EOS_CNT && cmp_in_order) begin
        state_d = ST_EOS;
      end else if (hdr_cnt_i == MOLD_HB_CNT) begin
        if (cmp_ahead) begin
          gap_v_d     = 1'b1;
          gap_start_d = cmp_exp;
          gap_len_d   = cmp_d;
        end
        state_d = ST_DROP;
      end else if (cmp_behind) begin
        if (cmp_dup_full) begin
          state_d = ST_DROP;
        end else begin
          cur_d   = hdr_seq_i;
          rem_d   = hdr_cnt_i;
          skip_d  = cmp_skip;
          exp_d   = hdr_seq_i + SEQ_W'(hdr_cnt_i);
          state_d = ST_PKT;
        end
      end else begin
        if (cmp_ahead) begin
          gap_v_d     = 1'b1;
          gap_start_d = cmp_exp;
          gap_len_d   = cmp_d;
        end
        cur_d   = hdr_seq_i;
        rem_d   = hdr_cnt_i;
        skip_d  = '0;
        exp_d   = hdr_seq_i + SEQ_W'(hdr_cnt_i);
        state_d = ST_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sid_q       <= '0;
      exp_q       <= '0;
      cur_q       <= '0;
      rem_q       <= '0;
      skip_q      <= '0;
      msg_v_o     <= 1'b0;
      msg_keep_o  <= 1'b0;
      msg_seq_o   <= '0;
      gap_v_o     <= 1'b0;
      gap_start_o <= '0;
      gap_len_o   <= '0;
      sid_err_o   <= 1'b0;
      cnt_err_o   <= 1'b0;
      eos_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sid_q       <= sid_d;
      exp_q       <= exp_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      skip_q      <= skip_d;
      msg_v_o     <= msg_end_v_i;
      msg_keep_o  <= msg_keep_d;
      msg_seq_o   <= msg_seq_d;
      gap_v_o     <= gap_v_d;
      gap_start_o <= gap_start_d;
      gap_len_o   <= gap_len_d;
      sid_err_o   <= sid_err_d;
      cnt_err_o   <= cnt_err_d;
      eos_o       <= (state_d == ST_EOS);
    end
  end

  assign exp_seq_o = exp_q;

endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Bench for mold_seq_ctrl: packet-level reference model checked every cycle, directed pins, random packets.
module tb_mold_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hdr_v = 1'b0;
  logic [79:0] hdr_sid = '0;
  logic [63:0] hdr_seq = '0;
  logic [15:0] hdr_cnt = '0;
  logic        msg_end_v = 1'b0;
  logic        pkt_last = 1'b0;

  logic        msg_v_o, msg_keep_o, gap_v_o, sid_err_o, cnt_err_o, eos_o;
  logic [63:0] msg_seq_o, exp_seq_o, gap_start_o, gap_len_o;

  localparam logic [79:0] S  = 80'h0123_4567_89AB_CDEF_0011;
  localparam logic [79:0] S2 = 80'h0123_4567_89AB_CDEF_0022;

  always #5 clk = ~clk;

  mold_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hdr_v_i     (hdr_v),
    .hdr_sid_i   (hdr_sid),
    .hdr_seq_i   (hdr_seq),
    .hdr_cnt_i   (hdr_cnt),
    .msg_end_v_i (msg_end_v),
    .pkt_last_i  (pkt_last),
    .msg_v_o     (msg_v_o),
    .msg_keep_o  (msg_keep_o),
    .msg_seq_o   (msg_seq_o),
    .exp_seq_o   (exp_seq_o),
    .gap_v_o     (gap_v_o),
    .gap_start_o (gap_start_o),
    .gap_len_o   (gap_len_o),
    .sid_err_o   (sid_err_o),
    .cnt_err_o   (cnt_err_o),
    .eos_o       (eos_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: session lock, expected seq, and the current packet as base/count/messages-seen.
  localparam int M_NONE = 0, M_BETWEEN = 1, M_ACC = 2, M_DROP = 3, M_EOS = 4;
  int          mode = M_NONE;
  logic [79:0] m_sid = '0;
  logic [63:0] m_exp = '0;
  logic [63:0] base = '0, old_exp = '0;
  int          pcnt = 0, k = 0;
  bit          chk_en = 0;

  logic        e_msg_v, e_keep, e_gap_v, e_sid_err, e_cnt_err, e_eos;
  logic [63:0] e_seq, e_exp, e_gap_start, e_gap_len;

  always @(posedge clk) begin
    logic [63:0]        cur;
    logic signed [63:0] sd, se;
    if (reset) begin
      mode = M_NONE; m_exp = '0; m_sid = '0;
      e_msg_v = 0; e_keep = 0; e_seq = '0; e_gap_v = 0; e_gap_start = '0; e_gap_len = '0;
      e_sid_err = 0; e_cnt_err = 0; e_eos = 0;
      chk_en = 1;
    end else begin
      e_msg_v = msg_end_v; e_keep = 0; e_gap_v = 0; e_sid_err = 0; e_cnt_err = 0;
      if (msg_end_v) begin
        if (mode == M_ACC) begin
          cur   = base + 64'(k);
          e_seq = cur;
          if (k < pcnt) begin
            sd     = cur - old_exp;
            e_keep = (sd >= 0);
            k++;
          end else begin
            e_cnt_err = 1;
          end
        end else begin
          e_seq = m_exp;
        end
      end
      if ((pkt_last || hdr_v) && (mode == M_ACC || mode == M_DROP)) begin
        if (mode == M_ACC && k < pcnt) begin
          e_cnt_err = 1;
          m_exp     = base + 64'(k);
        end
        mode = M_BETWEEN;
      end
      if (hdr_v && (mode == M_NONE || mode == M_BETWEEN)) begin
        if (mode == M_NONE) begin m_sid = hdr_sid; m_exp = hdr_seq; end
        sd = hdr_seq - m_exp;
        se = hdr_seq + 64'(hdr_cnt) - m_exp;
        if (hdr_sid != m_sid) begin
          e_sid_err = 1; mode = M_DROP;
        end else if (hdr_cnt == 16'hFFFF && sd == 0) begin
          mode = M_EOS;
        end else if (hdr_cnt == 16'h0000) begin
          if (sd > 0) begin e_gap_v = 1; e_gap_start = m_exp; e_gap_len = sd; end
          mode = M_DROP;
        end else if (sd < 0 && se <= 0) begin
          mode = M_DROP;
        end else begin
          if (sd > 0) begin e_gap_v = 1; e_gap_start = m_exp; e_gap_len = sd; end
          old_exp = m_exp;
          base    = hdr_seq;
          pcnt    = int'(hdr_cnt);
          k       = 0;
          m_exp   = hdr_seq + 64'(hdr_cnt);
          mode    = M_ACC;
        end
      end
    end
    e_exp = m_exp;
    e_eos = (mode == M_EOS);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("msg_v", 64'(msg_v_o), 64'(e_msg_v));
      if (e_msg_v) begin
        chk("msg_keep", 64'(msg_keep_o), 64'(e_keep));
        chk("msg_seq", msg_seq_o, e_seq);
      end
      chk("exp_seq", exp_seq_o, e_exp);
      chk("gap_v", 64'(gap_v_o), 64'(e_gap_v));
      if (e_gap_v) begin
        chk("gap_start", gap_start_o, e_gap_start);
        chk("gap_len", gap_len_o, e_gap_len);
      end
      chk("sid_err", 64'(sid_err_o), 64'(e_sid_err));
      chk("cnt_err", 64'(cnt_err_o), 64'(e_cnt_err));
      chk("eos", 64'(eos_o), 64'(e_eos));
    end
  end

  task automatic cyc(input logic h, input logic [79:0] s, input logic [63:0] q,
                     input logic [15:0] c, input logic me, input logic pl);
    hdr_v = h; hdr_sid = s; hdr_seq = q; hdr_cnt = c; msg_end_v = me; pkt_last = pl;
    @(negedge clk);
    hdr_v = 0; msg_end_v = 0; pkt_last = 0;
  endtask

  task automatic hdr(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c);
    cyc(1'b1, s, q, c, 1'b0, 1'b0);
  endtask

  task automatic msg(input logic pl);
    cyc(1'b0, S, '0, '0, 1'b1, pl);
  endtask

  task automatic idle();
    cyc(1'b0, S, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rst_cyc();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  task automatic pin_v(input logic keep, input logic [63:0] seq);
    chk("pin_msg_v", 64'(msg_v_o), 64'd1);
    chk("pin_keep", 64'(msg_keep_o), 64'(keep));
    chk("pin_seq", msg_seq_o, seq);
  endtask

  initial begin
    logic [79:0] s;
    logic [63:0] q;
    logic [15:0] c;
    int          nmsg, lastmode;

    reset = 1'b1;
    @(negedge clk);
    idle();
    reset = 1'b0;
    chk("pin_rst_msg_v", 64'(msg_v_o), 64'd0);
    chk("pin_rst_exp", exp_seq_o, 64'd0);
    chk("pin_rst_seq", msg_seq_o, 64'd0);
    chk("pin_rst_gap", gap_start_o | gap_len_o, 64'd0);
    chk("pin_rst_eos", 64'(eos_o), 64'd0);

    // In-order packets 1..3 and 4..5
    hdr(S, 64'd1, 16'd3);
    msg(0); pin_v(1, 64'd1);
    msg(0); pin_v(1, 64'd2);
    msg(1); pin_v(1, 64'd3);
    hdr(S, 64'd4, 16'd2);
    msg(0); pin_v(1, 64'd4);
    msg(1); pin_v(1, 64'd5);
    idle();
    chk("pin_exp6", exp_seq_o, 64'd6);

    // Gap 6..9
    hdr(S, 64'd10, 16'd1);
    chk("pin_gap_v", 64'(gap_v_o), 64'd1);
    chk("pin_gap_start", gap_start_o, 64'd6);
    chk("pin_gap_len", gap_len_o, 64'd4);
    msg(1); pin_v(1, 64'd10);
    chk("pin_exp11", exp_seq_o, 64'd11);

    // Partial overlap then full duplicate
    hdr(S, 64'd9, 16'd4);
    msg(0); pin_v(0, 64'd9);
    msg(0); pin_v(0, 64'd10);
    msg(0); pin_v(1, 64'd11);
    msg(1); pin_v(1, 64'd12);
    hdr(S, 64'd5, 16'd2);
    msg(0); pin_v(0, 64'd13);
    msg(1); pin_v(0, 64'd13);
    chk("pin_exp13", exp_seq_o, 64'd13);

    // Short packet
    hdr(S, 64'd13, 16'd3);
    msg(0); msg(0);
    cyc(1'b0, S, '0, '0, 1'b0, 1'b1);
    chk("pin_cnt_err", 64'(cnt_err_o), 64'd1);
    chk("pin_exp15", exp_seq_o, 64'd15);

    // Foreign session, then end of session
    hdr(S2, 64'd15, 16'd1);
    chk("pin_sid_err", 64'(sid_err_o), 64'd1);
    msg(1); pin_v(0, 64'd15);
    chk("pin_exp15b", exp_seq_o, 64'd15);
    hdr(S, 64'd15, 16'hFFFF);
    chk("pin_eos", 64'(eos_o), 64'd1);
    hdr(S, 64'd15, 16'd1);
    msg(1); pin_v(0, 64'd15);
    chk("pin_eos_held", 64'(eos_o), 64'd1);

    // Wraparound, then reset mid-packet
    rst_cyc();
    hdr(S, 64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
    msg(0); pin_v(1, 64'hFFFF_FFFF_FFFF_FFFF);
    msg(1); pin_v(1, 64'd0);
    chk("pin_exp_wrap", exp_seq_o, 64'd1);
    hdr(S, 64'd1, 16'd3);
    msg(0);
    rst_cyc();
    chk("pin_mid_rst_exp", exp_seq_o, 64'd0);
    chk("pin_mid_rst_msg_v", 64'(msg_v_o), 64'd0);
    chk("pin_mid_rst_seq", msg_seq_o, 64'd0);
    msg(0);
    chk("pin_post_rst_keep", 64'(msg_keep_o), 64'd0);
    msg(1);

    // Random packets near the expected sequence number
    for (int p = 0; p < 400; p++) begin
      if ($urandom_range(0, 39) == 0) rst_cyc();
      s = (mode != M_NONE && $urandom_range(0, 15) == 0) ? S2 : S;
      if (mode == M_NONE && $urandom_range(0, 1) == 1)
        q = 64'hFFFF_FFFF_FFFF_FFFC;
      else
        q = m_exp + 64'($urandom_range(0, 8)) - 64'd4;
      case ($urandom_range(0, 49))
        0:       c = 16'hFFFF;
        1, 2, 3: c = 16'h0000;
        default: c = 16'($urandom_range(1, 5));
      endcase
      if (c == 16'hFFFF) nmsg = $urandom_range(0, 2);
      else if (c == 16'h0000) nmsg = $urandom_range(0, 1);
      else nmsg = int'(c) + $urandom_range(0, 2) - 1;
      lastmode = $urandom_range(0, 2);
      hdr(s, q, c);
      for (int i = 0; i < nmsg; i++) begin
        if ($urandom_range(0, 2) == 0) idle();
        if ($urandom_range(0, 99) == 0) rst_cyc();
        msg((i == nmsg - 1) && lastmode == 0);
      end
      if (lastmode == 1 || (lastmode == 0 && nmsg == 0))
        cyc(1'b0, S, '0, '0, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mold_seq_ctrl.md
# mold_seq_ctrl

Per-session sequence controller for the MoldUDP64 receive path. Takes parsed downstream-packet header fields and the message-end strobes from the data dispatcher. Tracks the expected sequence number, and issues a commit/discard verdict with a sequence number for every message the dispatcher delimits. Also reports gaps, duplicates, session mismatches, message-count errors and end-of-session to the retransmission-request logic.

## Interface
- SID_W, 80, session field width (10 bytes)
- SEQ_W, 64, sequence number width
- CNT_W, 16, message count width
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- hdr_v_i  in  1  header fields valid; one pulse per packet, on the dispatcher init beat
- hdr_sid_i  in  SID_W  session
- hdr_seq_i  in  SEQ_W  sequence number of the packet's first message
- hdr_cnt_i  in  CNT_W  message count
- msg_end_v_i  in  1  dispatcher message-end strobe
- pkt_last_i  in  1  valid & last beat of packet
- msg_v_o  out  1  verdict pulse for the message that ended the previous cycle
- msg_keep_o  out  1  1 = commit, 0 = discard; meaningful when msg_v_o
- msg_seq_o  out  SEQ_W  sequence number of that message
- exp_seq_o  out  SEQ_W  next expected sequence number
- gap_v_o  out  1  gap pulse
- gap_start_o  out  SEQ_W  first missing sequence number
- gap_len_o  out  SEQ_W  number of missing messages
- sid_err_o  out  1  session mismatch pulse
- cnt_err_o  out  1  message count mismatch pulse
- eos_o  out  1  end-of-session level

## Operation
- States: IDLE (no session locked), WAIT (between packets), PKT (accepting), DROP (discarding until pkt_last_i), EOS (terminal).
- Serial compare: d = hdr_seq_i - exp (mod 2^SEQ_W). The packet is classified as:
  - in-order when d == 0
  - ahead when d != 0 and d[SEQ_W-1] == 0
  - behind otherwise
- IDLE + hdr_v_i: lock sid, set exp = hdr_seq_i, then apply the WAIT rules.
- WAIT + hdr_v_i:
  - Sid mismatch: sid_err_o, -> DROP.
  - hdr_cnt_i == 16'hFFFF with in-order seq: -> EOS, eos_o = 1.
  - hdr_cnt_i == 0 (heartbeat): ahead -> gap_v_o with gap_start = exp, gap_len = d; exp is unchanged. Then -> DROP.
  - Ahead: gap_v_o as above, cur = hdr_seq_i, rem = hdr_cnt_i, skip = 0, exp = hdr_seq_i + hdr_cnt_i. -> PKT.
  - In-order: same as ahead without the gap. -> PKT.
  - Behind with hdr_seq_i + hdr_cnt_i <= exp (serial): full duplicate, -> DROP.
  - Behind with partial overlap: skip = exp - hdr_seq_i (fits CNT_W), cur = hdr_seq_i, rem = hdr_cnt_i, exp = hdr_seq_i + hdr_cnt_i. -> PKT.
- PKT + msg_end_v_i:
  - When rem != 0: verdict msg_keep = (skip == 0), msg_seq = cur; then cur += 1, rem -= 1, and skip -= 1 if nonzero.
  - When rem == 0: cnt_err_o, verdict keep = 0, msg_seq = cur.
- PKT + pkt_last_i:
  - If rem != 0 after this cycle's message: cnt_err_o and exp = cur, counting this cycle's message.
  - -> WAIT.
- DROP: every msg_end_v_i gives a verdict with keep = 0, msg_seq = exp. pkt_last_i -> WAIT.
- EOS: all headers are ignored. Verdicts keep = 0. Only reset exits.
- hdr_v_i arriving in PKT or DROP (missing last): close the old packet as if pkt_last_i had occurred that cycle, including cnt_err_o if applicable, then process the header.
- msg_end_v_i together with pkt_last_i: the message is counted first, then the end check is made.

## Timing
- All outputs are registered.
- The header decision takes effect one cycle after hdr_v_i. gap_v_o, sid_err_o and eos_o rise at N+1.
- msg_v_o / msg_keep_o / msg_seq_o pulse exactly at N+1 for msg_end_v_i at N. Downstream buffers message bytes and commits or discards on msg_v_o.
- msg_end_v_i never coincides with hdr_v_i (the dispatcher minimum message length guarantees this).
- Throughput: one verdict per cycle, sustained.
- Reset values:
  - state IDLE
  - all pulse outputs 0, eos_o 0
  - exp_seq_o, msg_seq_o, gap_start_o, gap_len_o all 0
- Reset mid-packet discards the in-flight state. Verdicts for later msg_end_v_i are keep = 0 until the next hdr_v_i.
- Sequence arithmetic wraps modulo 2^SEQ_W: exp = 2^64-1 plus 2 messages gives exp = 1.

## Structure
- Package moldudp64_pkg: SID_W/SEQ_W/CNT_W, MOLD_EOS_CNT = 16'hFFFF, MOLD_HB_CNT = 0, state enum.
- Sub-module mold_seq_cmp: combinational serial comparator. Outputs d, in_order, ahead, behind, dup_full, skip.

## Test plan
- Session S, seq 1 cnt 3, then seq 4 cnt 2: five verdicts keep = 1, seq 1..5. exp_seq_o = 6. No error pulses.
- exp = 6, header seq 10 cnt 1: gap_v_o, gap_start = 6, gap_len = 4. Verdict seq 10 keep = 1. exp = 11.
- exp = 11, header seq 9 cnt 4: verdicts 9, 10 keep = 0; 11, 12 keep = 1. exp = 13. Header seq 5 cnt 2: DROP, all keep = 0.
- exp = 13, header cnt 3 but only 2 msg_end_v_i before pkt_last_i: cnt_err_o pulse, exp = 15.
- Header with sid != S: sid_err_o, verdicts keep = 0, exp unchanged. In-order header cnt 16'hFFFF: eos_o = 1 held, later headers ignored.
- exp = 2^64-1, cnt 2: verdicts 2^64-1, 0. exp = 1. Assert reset mid-packet: all outputs 0, state IDLE next cycle.
